// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type and default operand/counter widths.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_FINISH
  } state_e;

  // Ops 0-3 are multi-cycle arithmetic; bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic op_is_arith(logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the instruction controller and the
// multiply/divide sequencer.
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             mf_req;
  logic             hilo_sel;
  logic [WIDTH-1:0] read_data;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, operand_a, operand_b, mf_req, hilo_sel,
    input  read_data, busy, done, stall
  );

  modport slave (
    input  start, op, operand_a, operand_b, mf_req, hilo_sel,
    output read_data, busy, done, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc_hi, acc_lo} pair.
// Multiply: acc_lo holds the multiplier, operand the multiplicand.
// Divide:   acc_hi holds the partial remainder, acc_lo the dividend/quotient,
//           operand the divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // Shift-add for multiply, shift/trial-subtract for divide.
  always_comb begin
    sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    rem_sh   = {acc_hi_i, acc_lo_i[WIDTH-1]};
    // Only used when rem_sh >= divisor, so the true difference fits in WIDTH bits.
    diff     = rem_sh[WIDTH-1:0] - operand_i;
    acc_hi_o = sum[WIDTH:1];
    acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (rem_sh >= {1'b0, operand_i}) begin
        acc_hi_o = diff;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_o = rem_sh[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Operands are
// made non-negative on entry, WIDTH radix-2 steps run in COMPUTE, and
// signs are restored in FINISH when HI/LO are written.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic                clk_i,
  input logic                rst_i,
  muldiv_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_q),
    .acc_hi_i  (acc_hi_q),
    .acc_lo_i  (acc_lo_q),
    .operand_i (operand_q),
    .acc_hi_o  (step_hi),
    .acc_lo_o  (step_lo)
  );

  // State register and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: accept work in IDLE, iterate in COMPUTE, sign fix-up and HI/LO write in FINISH.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = 1'b0;
    a_abs     = bus.operand_a;
    b_abs     = bus.operand_b;
    prod      = {acc_hi_q, acc_lo_q};
    prod_neg  = -prod;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_is_arith(bus.op)) begin
            signed_op = ~bus.op[0];
            if (signed_op && bus.operand_a[WIDTH-1]) a_abs = -bus.operand_a;
            if (signed_op && bus.operand_b[WIDTH-1]) b_abs = -bus.operand_b;
            is_div_d  = bus.op[1];
            acc_hi_d  = '0;
            // Divide keeps the dividend in acc_lo; multiply keeps the multiplier there.
            acc_lo_d  = bus.op[1] ? a_abs : b_abs;
            operand_d = bus.op[1] ? b_abs : a_abs;
            neg_res_d = signed_op & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_rem_d = signed_op & bus.operand_a[WIDTH-1];
            count_d   = '0;
            state_d   = S_COMPUTE;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.operand_a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.operand_a;
          end
        end
      end

      S_COMPUTE: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end else if (operand_q == '0) begin
          // Divide by zero: the restoring loop naturally leaves all-ones
          // quotient and the dividend magnitude as remainder; no sign fix.
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end else begin
          lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.read_data = bus.hilo_sel ? hi_q : lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall     = busy_q & (bus.start | bus.mf_req);

endmodule
